// File: rtl/pipe_sel_mux.sv
// ---------------------------------------------------------------------------
// pipe_sel_mux
//
// Registered N-input select stage for a pipeline boundary (ID/EX or EX/MEM).
// One of NUM_IN sources is selected by sel and captured in the output
// register together with a valid bit. The stage honours stall (hold) and
// flush (bubble insert, wins over stall). Accepted transfers whose select
// code is out of range return source 0. Each one also sets a sticky flag and
// bumps a saturating counter, so the condition stays visible for debug.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset, overrides all other inputs
//   in_data        flattened sources, source k at [k*WIDTH +: WIDTH]
//   sel            source select code
//   valid_in       upstream data/select valid
//   stall          hold out/valid_out
//   flush          clear out/valid_out (bubble)
//   clr_err        clear bad_sel_sticky and bad_cnt
//   out            registered selected data
//   valid_out      out holds a valid result
//   bad_sel_sticky an out-of-range select was accepted since the last clear
//   bad_cnt        saturating count of accepted out-of-range selects
// ---------------------------------------------------------------------------
module pipe_sel_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = $clog2(NUM_IN),
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    valid_in,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    clr_err,
    output logic [WIDTH-1:0]        out,
    output logic                    valid_out,
    output logic                    bad_sel_sticky,
    output logic [CNT_W-1:0]        bad_cnt
);

    // One-hot decode of sel. It is built as an AND-OR mux rather than an
    // array index, so that a code with no matching source decodes to an
    // all-zero hit vector. That vector is the out-of-range detector.
    logic [NUM_IN-1:0] hit;
    logic [WIDTH-1:0]  masked [NUM_IN];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_src
            assign hit[gi]    = (sel == SEL_W'(gi));
            assign masked[gi] = hit[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    logic [WIDTH-1:0] or_data;
    logic [WIDTH-1:0] sel_data;
    logic             sel_bad;

    always_comb begin
        or_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            or_data = or_data | masked[i];
        end
    end

    // An out-of-range code falls back to source 0.
    assign sel_bad  = ~|hit;
    assign sel_data = sel_bad ? in_data[WIDTH-1:0] : or_data;

    // Registers
    logic [WIDTH-1:0] out_reg,    out_next;
    logic             valid_reg,  valid_next;
    logic             sticky_reg, sticky_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic             accept;

    // rst_n is handled in the register process. It is not part of accept,
    // because reset already overrides every update.
    assign accept = valid_in & ~stall & ~flush;

    always_comb begin
        out_next    = out_reg;
        valid_next  = valid_reg;
        sticky_next = sticky_reg;
        cnt_next    = cnt_reg;

        if (flush) begin
            out_next   = '0;
            valid_next = 1'b0;
        end else if (!stall) begin
            // Load even when valid_in=0. Consumers qualify with valid_out.
            out_next   = sel_data;
            valid_next = valid_in;
        end

        // A clear in the same cycle as a bad accept wins, and the event is lost.
        if (clr_err) begin
            sticky_next = 1'b0;
            cnt_next    = '0;
        end else if (accept && sel_bad) begin
            sticky_next = 1'b1;
            if (cnt_reg != {CNT_W{1'b1}}) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg    <= '0;
            valid_reg  <= 1'b0;
            sticky_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            out_reg    <= out_next;
            valid_reg  <= valid_next;
            sticky_reg <= sticky_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign out            = out_reg;
    assign valid_out      = valid_reg;
    assign bad_sel_sticky = sticky_reg;
    assign bad_cnt        = cnt_reg;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// ---------------------------------------------------------------------------
// tb_pipe_sel_mux
//
// Three instances share the control inputs:
//   a: WIDTH=32, NUM_IN=3, CNT_W=8  (default configuration)
//   b: WIDTH=32, NUM_IN=3, CNT_W=2  (counter saturation)
//   c: WIDTH=16, NUM_IN=8, CNT_W=8  (power-of-two source count)
// A directed sequence is followed by a randomized phase. Every cycle is
// checked against a behavioural model of the select/stall/flush/error rules.
// ---------------------------------------------------------------------------
module tb_pipe_sel_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid_in, stall, flush, clr_err;
    logic [1:0]  sel_ab;
    logic [2:0]  sel_c;
    logic [31:0] src_ab [3];
    logic [15:0] src_c  [8];
    logic [95:0]  in_ab;
    logic [127:0] in_c;

    assign in_ab = {src_ab[2], src_ab[1], src_ab[0]};
    always_comb begin
        in_c = '0;
        for (int k = 0; k < 8; k++) in_c[k*16 +: 16] = src_c[k];
    end

    logic [31:0] a_out, b_out;
    logic [15:0] c_out;
    logic        a_vld, b_vld, c_vld, a_stk, b_stk, c_stk;
    logic [7:0]  a_cnt, c_cnt;
    logic [1:0]  b_cnt;

    pipe_sel_mux #(.WIDTH(32), .NUM_IN(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_ab), .sel(sel_ab),
        .valid_in(valid_in), .stall(stall), .flush(flush), .clr_err(clr_err),
        .out(a_out), .valid_out(a_vld), .bad_sel_sticky(a_stk), .bad_cnt(a_cnt));

    pipe_sel_mux #(.WIDTH(32), .NUM_IN(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_ab), .sel(sel_ab),
        .valid_in(valid_in), .stall(stall), .flush(flush), .clr_err(clr_err),
        .out(b_out), .valid_out(b_vld), .bad_sel_sticky(b_stk), .bad_cnt(b_cnt));

    pipe_sel_mux #(.WIDTH(16), .NUM_IN(8), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_c), .sel(sel_c),
        .valid_in(valid_in), .stall(stall), .flush(flush), .clr_err(clr_err),
        .out(c_out), .valid_out(c_vld), .bad_sel_sticky(c_stk), .bad_cnt(c_cnt));

    // Reference model state, one entry per instance.
    logic [31:0] exp_out    [3];
    logic        exp_valid  [3];
    logic        exp_sticky [3];
    int          exp_cnt    [3];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Apply this cycle's inputs to the model, following the stated rules.
    task automatic model_step();
        int  n, maxc, s, idx;
        bit  bad, acc;
        for (int d = 0; d < 3; d++) begin
            n    = (d == 2) ? 8 : 3;
            maxc = (d == 1) ? 3 : 255;
            s    = (d == 2) ? int'(sel_c) : int'(sel_ab);
            bad  = (s >= n);
            idx  = bad ? 0 : s;
            acc  = valid_in && !stall && !flush;
            if (!rst_n) begin
                exp_out[d] = 0; exp_valid[d] = 0; exp_sticky[d] = 0; exp_cnt[d] = 0;
            end else begin
                if (flush) begin
                    exp_out[d] = 0; exp_valid[d] = 0;
                end else if (!stall) begin
                    exp_out[d]   = (d == 2) ? {16'h0, src_c[idx]} : src_ab[idx];
                    exp_valid[d] = valid_in;
                end
                if (clr_err) begin
                    exp_sticky[d] = 0; exp_cnt[d] = 0;
                end else if (acc && bad) begin
                    exp_sticky[d] = 1;
                    exp_cnt[d]    = (exp_cnt[d] + 1 > maxc) ? maxc : exp_cnt[d] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_out", a_out, exp_out[0]);
        chk("a_valid", 32'(a_vld), 32'(exp_valid[0]));
        chk("a_sticky", 32'(a_stk), 32'(exp_sticky[0]));
        chk("a_cnt", 32'(a_cnt), 32'(exp_cnt[0]));
        chk("b_out", b_out, exp_out[1]);
        chk("b_valid", 32'(b_vld), 32'(exp_valid[1]));
        chk("b_sticky", 32'(b_stk), 32'(exp_sticky[1]));
        chk("b_cnt", 32'(b_cnt), 32'(exp_cnt[1]));
        chk("c_out", {16'h0, c_out}, exp_out[2]);
        chk("c_valid", 32'(c_vld), 32'(exp_valid[2]));
        chk("c_sticky", 32'(c_stk), 32'(exp_sticky[2]));
        chk("c_cnt", 32'(c_cnt), 32'(exp_cnt[2]));
    endtask

    // Inputs are set before the call. The edge is taken and the outputs are
    // sampled 1 time unit after it.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic set_in(input logic v, input logic st, input logic fl,
                          input logic ce, input logic [1:0] sab, input logic [2:0] sc);
        valid_in = v; stall = st; flush = fl; clr_err = ce; sel_ab = sab; sel_c = sc;
    endtask

    int sat_seq [5] = '{1, 2, 3, 3, 3};

    initial begin
        src_ab[0] = 32'hAAAA0000;
        src_ab[1] = 32'hBBBB1111;
        src_ab[2] = 32'hCCCC2222;
        for (int k = 0; k < 8; k++) src_c[k] = 16'hA0A0 ^ 16'(k * 16'h1111);
        for (int d = 0; d < 3; d++) begin
            exp_out[d] = 0; exp_valid[d] = 0; exp_sticky[d] = 0; exp_cnt[d] = 0;
        end
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 2'd0, 3'd0);
        #1;

        // Reset for two cycles.
        cycle();
        cycle();
        chk("reset_a_out", a_out, 32'h0);

        // Basic select.
        rst_n = 1'b1;
        set_in(1, 0, 0, 0, 2'd0, 3'd0); cycle(); chk("sel0", a_out, 32'hAAAA0000);
        set_in(1, 0, 0, 0, 2'd1, 3'd1); cycle(); chk("sel1", a_out, 32'hBBBB1111);
        set_in(1, 0, 0, 0, 2'd2, 3'd2); cycle(); chk("sel2", a_out, 32'hCCCC2222);

        // Out-of-range select, three accepted, then clear.
        set_in(1, 0, 0, 0, 2'd3, 3'd3); cycle();
        chk("oor_out", a_out, 32'hAAAA0000);
        chk("oor_cnt1", 32'(a_cnt), 32'd1);
        set_in(1, 0, 0, 0, 2'd3, 3'd4); cycle();
        set_in(1, 0, 0, 0, 2'd3, 3'd5); cycle();
        chk("oor_cnt3", 32'(a_cnt), 32'd3);
        set_in(0, 0, 0, 1, 2'd0, 3'd6); cycle();
        chk("clr_cnt", 32'(a_cnt), 32'd0);

        // Stall holds, stall+flush clears.
        set_in(1, 0, 0, 0, 2'd1, 3'd1); cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 0, 2'(i), 3'(i + 2)); cycle();
        end
        chk("stall_hold", a_out, 32'hBBBB1111);
        set_in(1, 1, 1, 0, 2'd2, 3'd2); cycle();
        chk("flush_out", a_out, 32'h0);

        // Error gating. Bring a's count to 5 first.
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0, 2'd3, 3'd7); cycle();
        end
        set_in(1, 1, 0, 0, 2'd3, 3'd0); cycle();
        set_in(1, 0, 1, 0, 2'd3, 3'd0); cycle();
        set_in(0, 0, 0, 0, 2'd3, 3'd0); cycle();
        chk("gated_cnt5", 32'(a_cnt), 32'd5);
        set_in(1, 0, 0, 1, 2'd3, 3'd0); cycle();
        chk("clr_wins", 32'(a_cnt), 32'd0);

        // Saturation on the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0, 2'd3, 3'd0); cycle();
            chk("sat_seq", 32'(b_cnt), 32'(sat_seq[i]));
        end

        // Reset while stalled.
        set_in(1, 0, 0, 0, 2'd2, 3'd0); cycle();
        set_in(1, 1, 0, 0, 2'd0, 3'd0); cycle();
        rst_n = 1'b0; cycle();
        chk("rst_in_stall", a_out, 32'h0);
        rst_n = 1'b1;

        // Sweep all eight sources on the NUM_IN=8 instance.
        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, 0, 0, 2'd0, 3'(i)); cycle();
            chk("c_sweep", {16'h0, c_out}, {16'h0, src_c[i]});
        end
        chk("c_cnt_zero", 32'(c_cnt), 32'd0);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) src_ab[k] = $urandom;
            for (int k = 0; k < 8; k++) src_c[k] = 16'($urandom);
            rst_n = ($urandom_range(0, 31) != 0);
            set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                   2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
